// File: rtl/modexp_ctl.sv
// modexp_ctl: right-to-left square-and-multiply modular exponentiation over a toggle-handshake remainder unit.
// Define MODEXP_EARLY_EXIT_EN to finish as soon as the remaining exponent is zero.
module modexp_ctl #(
  parameter int MSB = 7
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  input  logic               req,
  output logic               ack,
  input  logic [MSB:0]       base,
  input  logic [MSB:0]       exponent,
  input  logic [MSB:0]       modulus,
  output logic [MSB:0]       result,
  output logic               mod_err,
  output logic               rem_req,
  input  logic               rem_ack,
  output logic [2*MSB+1:0]   rem_data_1,
  output logic [MSB:0]       rem_data_2,
  input  logic [MSB:0]       rem_result
);
  localparam int W = MSB + 1;
  localparam int W2 = 2 * W;
  localparam int CW = $clog2(W + 1);
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, HOLD, WAIT, STEP, DONE} state_t;
  typedef enum logic [1:0] {OP_RED, OP_MUL, OP_SQR} op_t;
  state_t state;
  op_t op;
  logic req_d;
  logic [MSB:0] m, e, acc, sq;
  logic [CW-1:0] cnt;
  logic [W2-1:0] prod;
  logic req_x;
  assign req_x = req ^ req_d;
  assign ack = state == IDLE;
  always_comb
    prod = op == OP_RED ? W2'(sq) : op == OP_MUL ? W2'(acc) * W2'(sq) : W2'(sq) * W2'(sq);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      op <= OP_RED;
      req_d <= 1'b0;
      m <= '0;
      e <= '0;
      acc <= '0;
      sq <= '0;
      cnt <= '0;
      result <= '0;
      mod_err <= 1'b0;
      rem_req <= 1'b0;
      rem_data_1 <= '0;
      rem_data_2 <= '0;
    end else if (enable) begin
      req_d <= req;
      case (state)
        IDLE: if (req_x) state <= LOAD;
        LOAD: begin
          sq <= base;
          e <= exponent;
          m <= modulus;
          cnt <= '0;
          op <= OP_RED;
          mod_err <= 1'b0;
          // The remainder unit reads the divisor as signed, so zero and negative moduli are rejected
          if (modulus == '0 || modulus[MSB]) begin
            mod_err <= 1'b1;
            result <= '0;
            acc <= '0;
            state <= DONE;
          end else if (modulus == W'(1)) begin
            result <= '0;
            acc <= '0;
            state <= DONE;
          end else begin
            acc <= W'(1);
            state <= ISSUE;
          end
        end
        ISSUE: begin
          rem_data_1 <= prod;
          rem_data_2 <= m;
          rem_req <= ~rem_req;
          state <= HOLD;
        end
        HOLD: state <= WAIT;
        WAIT: if (rem_ack) begin
          if (op == OP_MUL) acc <= rem_result;
          else sq <= rem_result;
          state <= STEP;
        end
        STEP: begin
          // A bit is consumed (e shifted) when its square is committed
          if (op == OP_SQR && cnt == CW'(W)) state <= DONE;
          else if (op != OP_MUL && e[0]) begin
            op <= OP_MUL;
            state <= ISSUE;
          end else begin
            e <= e >> 1;
            cnt <= cnt + 1'b1;
            op <= OP_SQR;
`ifdef MODEXP_EARLY_EXIT_EN
            state <= (e >> 1) == '0 ? DONE : ISSUE;
`else
            state <= ISSUE;
`endif
          end
        end
        DONE: begin
          result <= acc;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_modexp_ctl.sv
// tb_modexp_ctl: directed checks of modexp_ctl against a behavioural remainder unit.
module tb_modexp_ctl;
  logic clk = 1'b0, rstn = 1'b0, enable = 1'b1, req = 1'b0;
  logic ack, mod_err, rem_req, rem_ack;
  logic [7:0] base = '0, exponent = '0, modulus = '0, result, rem_data_2, rem_result;
  logic [15:0] rem_data_1;
  int checks = 0, failures = 0;
  int tgl = 0, stall_at = -1, busy;
  logic seen;
  logic [15:0] log1 [64];
  logic [7:0] log2 [64];
`ifdef MODEXP_EARLY_EXIT_EN
  localparam int T1 = 5, T2 = 4, T3 = 1, T4 = 3;
`else
  localparam int T1 = 11, T2 = 11, T3 = 9, T4 = 10;
`endif

  modexp_ctl #(.MSB(7)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .req(req), .ack(ack),
    .base(base), .exponent(exponent), .modulus(modulus), .result(result),
    .mod_err(mod_err), .rem_req(rem_req), .rem_ack(rem_ack),
    .rem_data_1(rem_data_1), .rem_data_2(rem_data_2), .rem_result(rem_result)
  );

  always #5 clk = ~clk;

  // Remainder unit: drops ack one cycle after a toggle, answers a few cycles later
  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      seen <= 1'b0;
      rem_ack <= 1'b1;
      busy <= 0;
      rem_result <= '0;
    end else if (rem_req != seen) begin
      seen <= rem_req;
      rem_ack <= 1'b0;
      busy <= (tgl == stall_at) ? 22 : 2;
      log1[tgl[5:0]] <= rem_data_1;
      log2[tgl[5:0]] <= rem_data_2;
      tgl <= tgl + 1;
    end else if (!rem_ack) begin
      if (busy == 0) begin
        rem_ack <= 1'b1;
        rem_result <= 8'(rem_data_1 % {8'h00, rem_data_2});
      end else busy <= busy - 1;
    end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic job(input logic [7:0] b, input logic [7:0] x, input logic [7:0] m, input int mode,
                     output logic [7:0] res, output logic err, output int tg, output int cyc);
    int t0;
    logic [15:0] d;
    bit fz = 0, st = 0, stable = 1;
    base = b;
    exponent = x;
    modulus = m;
    t0 = tgl;
    if (mode == 3) stall_at = t0 + 1;
    @(negedge clk);
    req = ~req;
    @(negedge clk);
    cyc = 1;
    chk("ack_busy", ack, 0);
    while (!ack && cyc < 3000) begin
      if (mode == 1 && cyc == 5) req = ~req;
      if (mode == 2 && !fz && rem_ack && tgl - t0 == 3) begin
        fz = 1;
        enable = 1'b0;
        repeat (5) @(negedge clk);
        cyc += 5;
        enable = 1'b1;
      end
      if (mode == 3 && !st && tgl - t0 == 2 && !rem_ack) begin
        st = 1;
        d = rem_data_1;
        repeat (15) begin
          @(negedge clk);
          cyc++;
          if (rem_data_1 !== d || rem_ack || ack) stable = 0;
        end
        chk("stall_stable", stable, 1);
        chk("stall_data", d, log1[6'(t0 + 1)]);
      end
      if (mode == 4 && tgl - t0 == 1 && !rem_ack) begin
        rstn = 1'b0;
        req = 1'b0;
        @(negedge clk);
        chk("rst_ack", ack, 1);
        chk("rst_result", result, 0);
        chk("rst_rem_req", rem_req, 0);
        rstn = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    if (mode != 4) chk("done_in_time", ack, 1);
    stall_at = -1;
    res = result;
    err = mod_err;
    tg = tgl - t0;
  endtask

  initial begin
    logic [7:0] res;
    logic err;
    int tg, cyc, cyc0, ts;
    repeat (3) @(negedge clk);
    chk("reset_ack", ack, 1);
    chk("reset_result", result, 0);
    chk("reset_mod_err", mod_err, 0);
    chk("reset_rem_req", rem_req, 0);
    chk("reset_rem_data_1", rem_data_1, 0);
    chk("reset_rem_data_2", rem_data_2, 0);
    rstn = 1'b1;
    @(negedge clk);
    ts = tgl;
    job(3, 5, 7, 0, res, err, tg, cyc0);
    chk("3^5%7", res, 5);
    chk("3^5%7_err", err, 0);
    chk("3^5%7_toggles", tg, T1);
    chk("3^5%7_divisor", log2[6'(ts)], 7);
    job(10, 3, 7, 0, res, err, tg, cyc);
    chk("10^3%7", res, 6);
    chk("10^3%7_toggles", tg, T2);
    job(2, 0, 5, 0, res, err, tg, cyc);
    chk("2^0%5", res, 1);
    chk("2^0%5_toggles", tg, T3);
    ts = tgl;
    job(100, 2, 127, 0, res, err, tg, cyc);
    chk("100^2%127", res, 94);
    chk("100^2%127_toggles", tg, T4);
    chk("first_dividend", log1[6'(ts)], 16'h0064);
    chk("square_dividend", log1[6'(ts + 1)], 16'h2710);
    job(5, 3, 0, 0, res, err, tg, cyc);
    chk("mod0_result", res, 0);
    chk("mod0_err", err, 1);
    chk("mod0_toggles", tg, 0);
    job(5, 3, 200, 0, res, err, tg, cyc);
    chk("mod200_err", err, 1);
    chk("mod200_toggles", tg, 0);
    job(5, 3, 1, 0, res, err, tg, cyc);
    chk("mod1_result", res, 0);
    chk("mod1_err", err, 0);
    chk("mod1_toggles", tg, 0);
    ts = tgl;
    job(3, 5, 7, 1, res, err, tg, cyc);
    chk("busy_req_result", res, 5);
    chk("busy_req_cycles", cyc, cyc0);
    repeat (20) @(negedge clk);
    chk("busy_req_no_rerun", ack, 1);
    chk("busy_req_toggles", tgl - ts, T1);
    job(3, 5, 7, 3, res, err, tg, cyc);
    chk("stall_result", res, 5);
    chk("stall_cycles", cyc, cyc0 + 20);
    job(3, 5, 7, 2, res, err, tg, cyc);
    chk("freeze_result", res, 5);
    chk("freeze_cycles", cyc, cyc0 + 5);
    job(3, 5, 7, 4, res, err, tg, cyc);
    @(negedge clk);
    job(3, 5, 7, 0, res, err, tg, cyc);
    chk("after_reset_result", res, 5);
    chk("after_reset_toggles", tg, T1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
